// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg: shared lane widths and complex word layout for the FFT input packer and output splitter.
package fft_stream_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAME_LEN = 1024;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] im;
    logic [DEF_DATA_W-1:0] re;
  } cplx_t;
endpackage

// File: rtl/fft_frame_packer_if.sv
// fft_frame_packer_if: real/imag input lanes and complex output stream of the FFT frame packer.
interface fft_frame_packer_if import fft_stream_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic [DATA_W-1:0] in1_Tdata, in2_Tdata;
  logic in1_Tvalid, in1_Tlast, in1_Tready;
  logic in2_Tvalid, in2_Tlast, in2_Tready;
  logic [2*DATA_W-1:0] out_Tdata;
  logic out_Tvalid, out_Tlast, out_Tready;
  modport master (
    output in1_Tdata, in1_Tvalid, in1_Tlast, in2_Tdata, in2_Tvalid, in2_Tlast, out_Tready,
    input in1_Tready, in2_Tready, out_Tdata, out_Tvalid, out_Tlast
  );
  modport slave (
    input in1_Tdata, in1_Tvalid, in1_Tlast, in2_Tdata, in2_Tvalid, in2_Tlast, out_Tready,
    output in1_Tready, in2_Tready, out_Tdata, out_Tvalid, out_Tlast
  );
endinterface

// File: rtl/axis_hold_reg.sv
// axis_hold_reg: 1-entry lane hold register; refills in the same cycle it is popped.
module axis_hold_reg #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic              i_pop,
  output logic              o_ready,
  output logic              o_hv,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  logic r_hv, r_last;
  logic [DATA_W-1:0] r_data;
  assign o_ready = !rst && (!r_hv || i_pop);
  assign o_hv = r_hv;
  assign o_data = r_data;
  assign o_last = r_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_hv <= 1'b1;
      r_data <= i_data;
      r_last <= i_last;
    end else if (i_pop) begin
      r_hv <= 1'b0;
    end
  end
endmodule

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: pairs real/imag lanes into {imag, real} words and regenerates Tlast from a frame counter.
module fft_frame_packer import fft_stream_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  fft_frame_packer_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             lane_err
);
  logic w_hv1, w_hv2, w_last1, w_last2, w_fire, w_wrap;
  logic [DATA_W-1:0] w_data1, w_data2;
  logic [2*DATA_W-1:0] r_data;
  logic r_valid, r_last, r_err;
  logic [CNT_W-1:0] r_cnt;
  axis_hold_reg #(.DATA_W(DATA_W)) u_hold1 (
    .clk(clk), .rst(rst), .i_data(bus.in1_Tdata), .i_valid(bus.in1_Tvalid), .i_last(bus.in1_Tlast),
    .i_pop(w_fire), .o_ready(bus.in1_Tready), .o_hv(w_hv1), .o_data(w_data1), .o_last(w_last1)
  );
  axis_hold_reg #(.DATA_W(DATA_W)) u_hold2 (
    .clk(clk), .rst(rst), .i_data(bus.in2_Tdata), .i_valid(bus.in2_Tvalid), .i_last(bus.in2_Tlast),
    .i_pop(w_fire), .o_ready(bus.in2_Tready), .o_hv(w_hv2), .o_data(w_data2), .o_last(w_last2)
  );
  assign w_fire = w_hv1 && w_hv2 && (!r_valid || bus.out_Tready);
  assign w_wrap = r_cnt == CNT_W'(FRAME_LEN - 1);
  assign bus.out_Tdata = r_data;
  assign bus.out_Tvalid = r_valid;
  assign bus.out_Tlast = r_last;
  assign frame_cnt = r_cnt;
  assign lane_err = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_fire) begin
      r_data <= {w_data2, w_data1};
      r_valid <= 1'b1;
      r_last <= w_wrap;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      // lane markers are only audited; framing always follows the counter
      if (w_last1 != w_wrap || w_last2 != w_wrap) r_err <= 1'b1;
    end else if (bus.out_Tready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_frame_packer.sv
// tb_fft_frame_packer: scoreboard bench driving FRAME_LEN=4 and FRAME_LEN=2 packers in lockstep.
module tb_fft_frame_packer;
  import fft_stream_pkg::*;
  typedef struct { cplx_t d; logic la; logic lb; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] fa_cnt;
  logic fb_cnt;
  logic ea, eb;
  exp_t q[$];
  int n_vec = 0, n_bad = 0, cyc = 0;
  int pops = 0, pop_first = 0, pop_last = 0, c0 = 0;
  int v1 = 1, v2 = 101, g1 = 0, g2 = 0, w = 0, err_beat = -1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fft_frame_packer_if #(.DATA_W(32)) ia ();
  fft_frame_packer_if #(.DATA_W(32)) ib ();
  fft_frame_packer #(.DATA_W(32), .FRAME_LEN(4)) u_a (.clk(clk), .rst(rst), .bus(ia), .frame_cnt(fa_cnt), .lane_err(ea));
  fft_frame_packer #(.DATA_W(32), .FRAME_LEN(2)) u_b (.clk(clk), .rst(rst), .bus(ib), .frame_cnt(fb_cnt), .lane_err(eb));
  assign ib.in1_Tdata = ia.in1_Tdata;
  assign ib.in1_Tvalid = ia.in1_Tvalid;
  assign ib.in2_Tdata = ia.in2_Tdata;
  assign ib.in2_Tvalid = ia.in2_Tvalid;
  assign ib.out_Tready = ia.out_Tready;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ready depends only on the lane holds, so both instances see identical handshakes
  always @(negedge clk) begin
    #2;
    if (!rst && ia.out_Tvalid) begin
      if (q.size() == 0) chk("spurious_valid", 64'(ia.out_Tvalid), 64'd0);
      else begin
        chk("a_data", ia.out_Tdata, 64'(q[0].d));
        chk("a_last", 64'(ia.out_Tlast), 64'(q[0].la));
        chk("b_valid", 64'(ib.out_Tvalid), 64'd1);
        chk("b_data", ib.out_Tdata, 64'(q[0].d));
        chk("b_last", 64'(ib.out_Tlast), 64'(q[0].lb));
        if (ia.out_Tready) begin
          void'(q.pop_front());
          if (pops == 0) pop_first = cyc;
          pop_last = cyc;
          pops++;
        end
      end
    end
  end

  task automatic stream(int n, int p2, bit rnd);
    int s1 = 0, s2 = 0, i = 0;
    for (int k = 0; k < n; k++)
      q.push_back('{d: '{im: 32'(v2 + k), re: 32'(v1 + k)}, la: ((w + k) % 4 == 3), lb: ((w + k) % 2 == 1)});
    w += n;
    while ((s1 < n || s2 < n) && i < 2000) begin
      @(negedge clk);
      ia.in1_Tvalid = s1 < n;
      ia.in2_Tvalid = (s2 < n) && (i % p2 == 0);
      ia.in1_Tdata = 32'(v1);
      ia.in2_Tdata = 32'(v2);
      ia.in1_Tlast = (g1 % 4 == 3) ^ (g1 == err_beat);
      ia.in2_Tlast = g2 % 4 == 3;
      ib.in1_Tlast = g1 % 2 == 1;
      ib.in2_Tlast = g2 % 2 == 1;
      ia.out_Tready = rnd ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (p2 == 3 && i == 2) chk("skew_in1_ready", 64'(ia.in1_Tready), 64'd0);
      if (ia.in1_Tvalid && ia.in1_Tready) begin s1++; v1++; g1++; end
      if (ia.in2_Tvalid && ia.in2_Tready) begin s2++; v2++; g2++; end
      i++;
    end
    chk("lane_beats", 64'(s1 + s2), 64'(2 * n));
    @(negedge clk);
    ia.in1_Tvalid = 1'b0;
    ia.in2_Tvalid = 1'b0;
    ia.out_Tready = 1'b1;
    i = 0;
    while (q.size() != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    {ia.in1_Tvalid, ia.in2_Tvalid, ia.in1_Tlast, ia.in2_Tlast, ib.in1_Tlast, ib.in2_Tlast} = '0;
    ia.in1_Tdata = '0;
    ia.in2_Tdata = '0;
    ia.out_Tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in1_ready", 64'(ia.in1_Tready), 64'd0);
    chk("rst_in2_ready", 64'(ia.in2_Tready), 64'd0);
    chk("rst_valid", 64'(ia.out_Tvalid), 64'd0);
    chk("rst_last", 64'(ia.out_Tlast), 64'd0);
    chk("rst_data", ia.out_Tdata, 64'd0);
    chk("rst_cnt", 64'(fa_cnt), 64'd0);
    chk("rst_err", 64'(ea), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in1_ready", 64'(ia.in1_Tready), 64'd1);
    chk("post_rst_in2_ready", 64'(ia.in2_Tready), 64'd1);
    // first drive at cyc=c0+1, accept edge c0+2, word visible after edge c0+3
    @(negedge clk);
    c0 = cyc;
    pops = 0;
    stream(8, 1, 1'b0);
    chk("latency", 64'(pop_first - c0), 64'd3);
    chk("throughput", 64'(pop_last - pop_first), 64'd7);
    chk("cnt_after_2_frames", 64'(fa_cnt), 64'd0);
    stream(8, 3, 1'b0);
    stream(200, 1, 1'b1);
    chk("err_clean", 64'(ea), 64'd0);
    err_beat = g1 + 2;
    stream(4, 1, 1'b0);
    chk("err_set", 64'(ea), 64'd1);
    err_beat = -1;
    stream(4, 1, 1'b0);
    chk("err_sticky", 64'(ea), 64'd1);
    chk("b_err_clean", 64'(eb), 64'd0);
    stream(2, 1, 1'b0);
    chk("cnt_mid_frame", 64'(fa_cnt), 64'd2);
    @(negedge clk);
    ia.in1_Tvalid = 1'b1;
    ia.in1_Tdata = 32'(v1);
    #1;
    chk("partial_ready", 64'(ia.in1_Tready), 64'd1);
    @(negedge clk);
    ia.in1_Tvalid = 1'b0;
    v1++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g1 = 0;
    g2 = 0;
    w = 0;
    #1;
    chk("mid_rst_valid", 64'(ia.out_Tvalid), 64'd0);
    chk("mid_rst_b_valid", 64'(ib.out_Tvalid), 64'd0);
    chk("mid_rst_cnt", 64'(fa_cnt), 64'd0);
    chk("mid_rst_b_cnt", 64'(fb_cnt), 64'd0);
    chk("mid_rst_err", 64'(ea), 64'd0);
    stream(4, 1, 1'b0);
    stream(6, 1, 1'b0);
    chk("b_err_final", 64'(eb), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
